// File: rtl/fifo_deq_packer.sv
// Drains narrow words from a BSV FIFO2-style dequeue port and packs `ratio`
// words into one wide beat on a registered valid/ready stream; FLUSH closes a partial beat.
module fifo_deq_packer #(
  parameter int unsigned width = 8,
  parameter int unsigned ratio = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [width-1:0]           FIFO_D_OUT,
  input  logic                       FIFO_EMPTY_N,
  output logic                       FIFO_DEQ,
  input  logic                       FLUSH,
  output logic [width*ratio-1:0]     OUT_DATA,
  output logic [$clog2(ratio+1)-1:0] OUT_CNT,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY
);

  localparam int unsigned DW = width * ratio;
  localparam int unsigned CW = $clog2(ratio + 1);
  localparam int unsigned KW = (ratio > 1) ? $clog2(ratio) : 1;

  typedef enum logic {FILL, HOLD} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic [DW-1:0]   data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   packed_w;
  logic            full;
  logic            deq;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FILL;
      k_q      <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    packed_w = shadow_q;
    for (int unsigned i = 0; i < ratio; i++) begin
      if (i == 32'(k_q)) packed_w[i*width +: width] = FIFO_D_OUT;
    end
    full = ((32'(k_q) + 32'd1) == ratio);
    unique case (state_q)
      FILL: begin
        if (deq && (full || FLUSH)) begin
          data_d   = packed_w;
          cnt_d    = CW'(k_q) + CW'(1);
          k_d      = '0;
          shadow_d = '0;
          state_d  = HOLD;
        end else if (deq) begin
          shadow_d = packed_w;
          k_d      = k_q + KW'(1);
        end else if (FLUSH && (k_q != '0)) begin
          data_d   = shadow_q;
          cnt_d    = CW'(k_q);
          k_d      = '0;
          shadow_d = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // Shadow is already clear here, so a word arriving on retire lands in lane 0.
        if (OUT_READY) begin
          state_d = FILL;
          if (deq) begin
            if (ratio == 1) begin
              data_d  = DW'(FIFO_D_OUT);
              cnt_d   = CW'(1);
              state_d = HOLD;
            end else begin
              shadow_d = DW'(FIFO_D_OUT);
              k_d      = KW'(1);
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    deq       = FIFO_EMPTY_N & ~RST & ((state_q == FILL) | OUT_READY);
    FIFO_DEQ  = deq;
    OUT_VALID = (state_q == HOLD);
    OUT_DATA  = data_q;
    OUT_CNT   = cnt_q;
  end

endmodule
